// File: rtl/t30_stack_node_if.sv
`default_nettype none
// ============================================================================
// Module   : t30_stack_node_if
// Brief    : One directional neighbour link of a stack node (push + pop).
// Revision : 1.0
// ============================================================================
interface t30_stack_node_if #(
  parameter int DATA_W = 11
);
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              in_ack;
  logic              out_req;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output in_data, in_ready, out_req,
    input  in_ack, out_data, out_ready
  );

  modport slave (
    input  in_data, in_ready, out_req,
    output in_ack, out_data, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/t30_stack_node.sv
`default_nettype none
// ============================================================================
// Module   : t30_stack_node
// Brief    : LIFO stack node with four fixed-priority push/pop neighbour ports.
// Revision : 1.0
// ============================================================================
module t30_stack_node #(
  parameter int         DATA_W = 11,
  parameter int         DEPTH  = 15,
  parameter logic [3:0] DIR_EN = 4'b1111,
  parameter int         CNT_W  = $clog2(DEPTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             reset,
  t30_stack_node_if.slave       left,
  t30_stack_node_if.slave       right,
  t30_stack_node_if.slave       up,
  t30_stack_node_if.slave       down,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  localparam int               c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_FULL  = CNT_W'(DEPTH);

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  logic [3:0]         w_in_ready;
  logic [3:0]         w_out_req;
  logic [DATA_W-1:0]  w_in_data [4];
  logic [3:0]         w_ack;
  logic [3:0]         w_gnt;
  logic               w_push;
  logic               w_pop;
  logic [DATA_W-1:0]  w_push_data;
  logic [DATA_W-1:0]  w_top;
  logic [c_IDX_W-1:0] w_top_idx;
  logic [c_IDX_W-1:0] w_wr_idx;
  logic               w_empty;
  logic               w_full;

  // Index 0..3 = left, right, up, down; this order is also the priority.
  assign w_in_ready = {down.in_ready, up.in_ready, right.in_ready, left.in_ready} & DIR_EN;
  assign w_out_req  = {down.out_req,  up.out_req,  right.out_req,  left.out_req}  & DIR_EN;

  assign w_in_data[0] = left.in_data;
  assign w_in_data[1] = right.in_data;
  assign w_in_data[2] = up.in_data;
  assign w_in_data[3] = down.in_data;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == c_FULL);
  assign w_top_idx = c_IDX_W'(count_q - 1'b1);
  assign w_top     = w_empty ? '0 : mem_q[w_top_idx];

  always_comb begin
    w_gnt = '0;
    w_pop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!w_pop && !w_empty && w_out_req[i]) begin
        w_gnt[i] = 1'b1;
        w_pop    = 1'b1;
      end
    end
  end

  // A full stack still accepts a push when the top is popped in the same cycle.
  always_comb begin
    w_ack       = '0;
    w_push      = 1'b0;
    w_push_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (!w_push && reset && (!w_full || w_pop) && w_in_ready[i]) begin
        w_ack[i]    = 1'b1;
        w_push      = 1'b1;
        w_push_data = w_in_data[i];
      end
    end
  end

  assign w_wr_idx = w_pop ? w_top_idx : c_IDX_W'(count_q);

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[w_wr_idx] <= w_push_data;
    end
  end

  assign left.in_ack     = w_ack[0];
  assign right.in_ack    = w_ack[1];
  assign up.in_ack       = w_ack[2];
  assign down.in_ack     = w_ack[3];
  assign left.out_ready  = w_gnt[0];
  assign right.out_ready = w_gnt[1];
  assign up.out_ready    = w_gnt[2];
  assign down.out_ready  = w_gnt[3];
  assign left.out_data   = w_top;
  assign right.out_data  = w_top;
  assign up.out_data     = w_top;
  assign down.out_data   = w_top;

  assign count = count_q;
  assign empty = w_empty;
  assign full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_t30_stack_node.sv
`default_nettype none
// ============================================================================
// Module   : tb_t30_stack_node
// Brief    : Directed scoreboard bench for t30_stack_node (full and masked).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_t30_stack_node;

  localparam int DW    = 11;
  localparam int DEPTH = 15;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    int            dir;
    logic [DW-1:0] data;
  } pop_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    a_in_ready = '0;
  logic [3:0]    a_out_req  = '0;
  logic [DW-1:0] a_in_data  [4];
  logic [3:0]    a_in_ack;
  logic [3:0]    a_out_ready;
  logic [DW-1:0] a_out_data [4];
  logic [CW-1:0] a_count;
  logic          a_empty;
  logic          a_full;

  logic [3:0]    b_in_ready = '0;
  logic [3:0]    b_out_req  = '0;
  logic [DW-1:0] b_in_data  [4];
  logic [3:0]    b_in_ack;
  logic [3:0]    b_out_ready;
  logic [DW-1:0] b_out_data [4];
  logic [CW-1:0] b_count;
  logic          b_empty;
  logic          b_full;

  t30_stack_node_if #(.DATA_W(DW)) ia [4] ();
  t30_stack_node_if #(.DATA_W(DW)) ib [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_conn
    assign ia[g].in_data  = a_in_data[g];
    assign ia[g].in_ready = a_in_ready[g];
    assign ia[g].out_req  = a_out_req[g];
    assign a_in_ack[g]    = ia[g].in_ack;
    assign a_out_ready[g] = ia[g].out_ready;
    assign a_out_data[g]  = ia[g].out_data;
    assign ib[g].in_data  = b_in_data[g];
    assign ib[g].in_ready = b_in_ready[g];
    assign ib[g].out_req  = b_out_req[g];
    assign b_in_ack[g]    = ib[g].in_ack;
    assign b_out_ready[g] = ib[g].out_ready;
    assign b_out_data[g]  = ib[g].out_data;
  end

  t30_stack_node #(.DATA_W(DW), .DEPTH(DEPTH), .DIR_EN(4'b1111)) u_dut_a (
    .clk(clk), .reset(reset),
    .left(ia[0]), .right(ia[1]), .up(ia[2]), .down(ia[3]),
    .count(a_count), .empty(a_empty), .full(a_full)
  );

  t30_stack_node #(.DATA_W(DW), .DEPTH(DEPTH), .DIR_EN(4'b0101)) u_dut_b (
    .clk(clk), .reset(reset),
    .left(ib[0]), .right(ib[1]), .up(ib[2]), .down(ib[3]),
    .count(b_count), .empty(b_empty), .full(b_full)
  );

  int   vectors = 0;
  int   errors  = 0;
  int   exp_ack [$];
  pop_t exp_pop [$];

  function automatic logic [DW-1:0] w(input int v);
    return DW'(v);
  endfunction

  function automatic int sx(input logic [DW-1:0] d);
    return int'($signed(d));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name, input int d);
    vectors++;
    errors++;
    $display("FAIL %s: dir %0d timed out, got no event, expected one (t=%0t)", name, d, $time);
  endtask

  // Scoreboard monitor: every ack/grant consumes the oldest expected event.
  always @(negedge clk) begin : p_mon
    int   ea;
    pop_t ep;
    if (reset) begin
      for (int g = 0; g < 4; g++) begin
        if (a_in_ack[g]) begin
          if (exp_ack.size() == 0) begin
            expire("unexpected_ack", g);
          end else begin
            ea = exp_ack.pop_front();
            check("ack_dir", g, ea);
          end
        end
        if (a_out_ready[g]) begin
          if (exp_pop.size() == 0) begin
            expire("unexpected_grant", g);
          end else begin
            ep = exp_pop.pop_front();
            check("pop_dir", g, ep.dir);
            check("pop_data", sx(a_out_data[g]), sx(ep.data));
          end
        end
      end
    end
  end

  // All driver tasks start and end one time unit after a rising edge.
  task automatic push_from(input int d, input int v);
    exp_ack.push_back(d);
    a_in_data[d]  = w(v);
    a_in_ready[d] = 1'b1;
    begin : b_wait
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (a_in_ack[d]) disable b_wait;
      end
      expire("push_wait", d);
    end
    @(posedge clk); #1;
    a_in_ready[d] = 1'b0;
  endtask

  task automatic pop_to(input int d, input int v);
    exp_pop.push_back('{dir: d, data: w(v)});
    a_out_req[d] = 1'b1;
    begin : b_wait
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (a_out_ready[d]) disable b_wait;
      end
      expire("pop_wait", d);
    end
    @(posedge clk); #1;
    a_out_req[d] = 1'b0;
  endtask

  initial begin : p_stim
    logic [3:0] done;
    for (int i = 0; i < 4; i++) begin
      a_in_data[i] = '0;
      b_in_data[i] = '0;
    end
    #2;
    check("rst_count", a_count, 0);
    check("rst_empty", a_empty, 1);
    check("rst_full", a_full, 0);
    check("rst_data", sx(a_out_data[3]), 0);
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // LIFO ordering
    push_from(0, 5);
    push_from(0, -3);
    push_from(0, 1023);
    check("order_count", a_count, 3);
    pop_to(3, 1023);
    pop_to(3, -3);
    pop_to(3, 5);
    check("order_empty", a_empty, 1);

    // Capacity, stall when full, push+pop while full
    for (int i = 1; i <= DEPTH; i++) push_from(0, i * 13 - 100);
    check("cap_full", a_full, 1);
    check("cap_count", a_count, DEPTH);
    exp_ack.push_back(2);
    a_in_data[2]  = w(500);
    a_in_ready[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_ack", a_in_ack[2], 0);
      check("stall_count", a_count, DEPTH);
    end
    @(posedge clk); #1;
    exp_pop.push_back('{dir: 1, data: w(DEPTH * 13 - 100)});
    a_out_req[1] = 1'b1;
    @(negedge clk);
    check("full_pp_ack", a_in_ack[2], 1);
    check("full_pp_gnt", a_out_ready[1], 1);
    @(posedge clk); #1;
    a_in_ready[2] = 1'b0;
    a_out_req[1]  = 1'b0;
    check("full_pp_count", a_count, DEPTH);
    check("full_pp_top", sx(a_out_data[0]), 500);
    pop_to(0, 500);
    for (int i = DEPTH - 1; i >= 1; i--) pop_to(0, i * 13 - 100);
    check("drain_empty", a_empty, 1);

    // Push arbitration: one ack per cycle in priority order
    for (int d = 0; d < 4; d++) begin
      exp_ack.push_back(d);
      a_in_data[d]  = w(d + 1);
      a_in_ready[d] = 1'b1;
    end
    for (int c = 0; c < 8 && a_in_ready != 4'b0000; c++) begin
      @(negedge clk);
      check("push_arb_one", $countones(a_in_ack), 1);
      done = a_in_ack;
      @(posedge clk); #1;
      a_in_ready = a_in_ready & ~done;
    end
    if (a_in_ready != 4'b0000) expire("push_arb", 0);
    a_in_ready = '0;
    pop_to(0, 4);
    pop_to(0, 3);
    pop_to(0, 2);
    pop_to(0, 1);

    // Pop arbitration, then empty wait, then push-through to waiting popper
    push_from(0, 7);
    push_from(0, 9);
    exp_pop.push_back('{dir: 1, data: w(9)});
    exp_pop.push_back('{dir: 3, data: w(7)});
    a_out_req[1] = 1'b1;
    a_out_req[3] = 1'b1;
    for (int c = 0; c < 4 && a_out_req != 4'b0000; c++) begin
      @(negedge clk);
      check("pop_arb_one", $countones(a_out_ready), 1);
      done = a_out_ready;
      @(posedge clk); #1;
      a_out_req = a_out_req & ~done;
    end
    if (a_out_req != 4'b0000) expire("pop_arb", 3);
    a_out_req[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("empty_no_gnt", a_out_ready[3], 0);
    end
    @(posedge clk); #1;
    exp_ack.push_back(0);
    exp_pop.push_back('{dir: 3, data: w(77)});
    a_in_data[0]  = w(77);
    a_in_ready[0] = 1'b1;
    @(negedge clk);
    check("thru_ack", a_in_ack[0], 1);
    check("thru_no_gnt", a_out_ready[3], 0);
    @(posedge clk); #1;
    a_in_ready[0] = 1'b0;
    @(negedge clk);
    check("thru_gnt", a_out_ready[3], 1);
    @(posedge clk); #1;
    a_out_req[3] = 1'b0;
    check("thru_empty", a_empty, 1);

    // Simultaneous push and pop replaces the top
    push_from(0, 10);
    push_from(0, 20);
    push_from(0, -1);
    exp_ack.push_back(0);
    exp_pop.push_back('{dir: 2, data: w(-1)});
    a_in_data[0]  = w(42);
    a_in_ready[0] = 1'b1;
    a_out_req[2]  = 1'b1;
    @(negedge clk);
    check("pp_ack", a_in_ack[0], 1);
    check("pp_gnt", a_out_ready[2], 1);
    @(posedge clk); #1;
    a_in_ready[0] = 1'b0;
    a_out_req[2]  = 1'b0;
    check("pp_count", a_count, 3);
    check("pp_top", sx(a_out_data[1]), 42);
    pop_to(0, 42);
    pop_to(0, 20);
    pop_to(0, 10);

    // Asynchronous reset in the middle of pending transfers
    push_from(0, 100);
    push_from(0, 200);
    a_in_data[1]  = w(300);
    a_in_ready[1] = 1'b1;
    a_out_req[3]  = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_count", a_count, 0);
    check("mid_rst_empty", a_empty, 1);
    check("mid_rst_full", a_full, 0);
    check("mid_rst_ack", a_in_ack, 0);
    check("mid_rst_gnt", a_out_ready, 0);
    check("mid_rst_data", sx(a_out_data[0]), 0);
    a_in_ready = '0;
    a_out_req  = '0;
    @(negedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Direction mask: right and down disabled
    b_in_data[1]  = w(99);
    b_in_ready[1] = 1'b1;
    b_out_req[3]  = 1'b1;
    b_in_data[0]  = w(11);
    b_in_ready[0] = 1'b1;
    @(negedge clk);
    check("mask_left_ack", b_in_ack[0], 1);
    check("mask_right_ack", b_in_ack[1], 0);
    check("mask_down_gnt", b_out_ready[3], 0);
    @(posedge clk); #1;
    b_in_ready[0] = 1'b0;
    @(negedge clk);
    check("mask_count1", b_count, 1);
    check("mask_right_ack2", b_in_ack[1], 0);
    check("mask_down_gnt2", b_out_ready[3], 0);
    @(posedge clk); #1;
    b_out_req[2] = 1'b1;
    @(negedge clk);
    check("mask_up_gnt", b_out_ready[2], 1);
    check("mask_up_data", sx(b_out_data[2]), 11);
    check("mask_down_gnt3", b_out_ready[3], 0);
    @(posedge clk); #1;
    b_out_req[2] = 1'b0;
    @(negedge clk);
    check("mask_count0", b_count, 0);
    check("mask_right_ack3", b_in_ack[1], 0);
    b_in_ready = '0;
    b_out_req  = '0;
    @(posedge clk); #1;

    check("ack_queue_left", exp_ack.size(), 0);
    check("pop_queue_left", exp_pop.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/t30_stack_node.md
# t30_stack_node

Parametrised LIFO stack memory node for the TIS-100 node grid, sitting alongside the T21 execution nodes and using the same four directional ports (left, right, up, down). Any neighbour may push a word into the node or pop the top word out of it. Arbitration between neighbours is fixed-priority, and a push and a pop may complete in the same cycle. Depth, data width and the set of active directions are parameters, so edge-of-grid instances can disable unused ports.

## Interface
- DATA_W, 11: word width in bits; signed two's-complement, carried unmodified.
- DEPTH, 15: stack capacity in words; must be at least 1.
- DIR_EN, 4'b1111: port enable mask, bit0=left, bit1=right, bit2=up, bit3=down. A disabled direction never acks or grants, and its inputs are ignored.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports (X ∈ {left, right, up, down}):
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- X_in_data  in  DATA_W  word offered by neighbour X for push.
- X_in_ready  in  1  neighbour X has a word to push.
- X_in_ack  out  1  push from X accepted this cycle; captured at the next edge.
- X_out_req  in  1  neighbour X wants to pop.
- X_out_data  out  DATA_W  current top of stack; identical on all four ports.
- X_out_ready  out  1  pop granted to X this cycle; X must take X_out_data this cycle.
- count  out  CNT_W  number of words held.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

## Operation
- Storage is DEPTH registers mem[0..DEPTH-1] plus a count register. The top of stack is mem[count-1].
- X_out_data is mem[count-1] when not empty, and 0 when empty.
- Fixed priority for both arbiters: left > right > up > down, masked by DIR_EN.
- Pop arbiter:
  - If not empty, grant the highest-priority X with X_out_req=1. Exactly that one X_out_ready is 1; all others are 0.
  - When empty, no grants are issued.
- Push arbiter:
  - Pick the highest-priority X with X_in_ready=1.
  - Accept it (X_in_ack=1) if count < DEPTH, or if a pop is granted in the same cycle.
  - At most one ack per cycle; all other acks are 0.
- State update at the clock edge:
  - Push only: mem[count] ← data, count+1.
  - Pop only: count−1. Memory is unchanged.
  - Push and pop together: mem[count-1] ← pushed data, count unchanged. The popper receives the old top.
  - Neither: hold.
- All ack and grant outputs are combinational from inputs and the current count. There is no combinational path from X_in_ready to X_out_ready.
- A neighbour that is both pushing and popping is treated as two independent requests.
- full / empty / count are registered state; they are never combinational from requests.

## Timing
- Reset asserted (reset=0): immediately and asynchronously count=0, empty=1, full=0.
  - All X_in_ack and X_out_ready are 0, and all X_out_data are 0.
  - mem contents are not cleared and are don't-care.
- Reset applied mid-transfer: that transfer is lost, and neither side may treat it as completed.
- First activity is allowed on the first rising edge after reset deasserts.
- Latency:
  - A word pushed at edge N is poppable in cycle N+1 (out_data valid, grant possible).
  - Throughput is one push and one pop per cycle.
- Neighbours hold X_in_ready and X_in_data until they see ack.
  - X_in_ready must deassert, or present the next word, in the cycle after ack.
  - Same rule for X_out_req versus X_out_ready.
- Boundary conditions:
  - Full with push only: no ack. The requester stalls indefinitely.
  - Full with push and pop: both proceed, count stays DEPTH.
  - Empty with pop request: no grant. Any push in that cycle is accepted, and its pop is granted next cycle.
  - count never exceeds DEPTH and never goes below 0.

## Test plan
- Reset and ordering:
  - Reset asserted mid-stream → count=0, empty=1, all acks/grants 0 without a clock edge.
  - Push 5, −3, 1023 from left, then pop from down → pops return 1023, −3, 5, then empty=1.
- Capacity (DEPTH=15):
  - Fill 15 words → full=1.
  - A 16th push from up stalls: up_in_ack=0 for 10 cycles, count=15.
  - A pop request on right in the same cycle → up_in_ack=1, right_out_ready=1, count stays 15.
- Push arbitration:
  - left, right, up and down all ready in one cycle with data 1, 2, 3, 4 → acks in order left, right, up, down on successive cycles.
  - Stack then pops 4, 3, 2, 1.
- Pop arbitration:
  - Stack holds 7, 9 (top 9); right and down request together.
  - → right granted and gets 9; down granted next cycle and gets 7.
  - Down then waits while empty, with no grant.
- Simultaneous push and pop:
  - Count=3, top=−1; left pushes 42 while up pops.
  - → up receives −1, count stays 3, next top is 42.
- Direction mask:
  - DIR_EN=4'b0101 (right and down disabled).
  - right_in_ready=1 and down_out_req=1 → never acked or granted; left and up operate normally.
